// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control inputs and divided outputs of clk_div_multi.
// Ports (signals): en, div_load, div_sel, div_val, sync_all (optional) -> ja, tick, pend.
// Optional sync_all is present only when CLK_DIV_MULTI_SYNC_EN is defined.
// master drives the controls and reads the outputs; slave is the divider side.
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic              div_load;
    logic [SEL_W-1:0]  div_sel;
    logic [CNT_W-1:0]  div_val;
    logic [NUM_CH-1:0] ja;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;
`ifdef CLK_DIV_MULTI_SYNC_EN
    logic              sync_all;

    modport master (
        output en, div_load, div_sel, div_val, sync_all,
        input  ja, tick, pend
    );
    modport slave (
        input  en, div_load, div_sel, div_val, sync_all,
        output ja, tick, pend
    );
`else
    modport master (
        output en, div_load, div_sel, div_val,
        input  ja, tick, pend
    );
    modport slave (
        input  en, div_load, div_sel, div_val,
        output ja, tick, pend
    );
`endif
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent run-time programmable clock dividers.
// Ports: clk (system clock), reset (async, active high), bus (clk_div_multi_if.slave):
//   en       per-channel run enable
//   div_load one-cycle divisor write strobe, div_sel target channel, div_val divisor
//   ja       divided outputs (~50% duty), tick period-start strobes, pend reload waiting
// Optional macro CLK_DIV_MULTI_SYNC_EN adds bus.sync_all to restart all channels in phase.
// A written divisor is held pending and only takes effect at a period boundary,
// or at once when the channel is not counting (disabled, divisor 0 or 1).
module clk_div_multi #(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned DEF_DIV = 100000000
) (
    input  logic           clk,
    input  logic           reset,
    clk_div_multi_if.slave bus
);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W:0]   ONE_W = (CNT_W+1)'(1);

    logic w_sync;

`ifdef CLK_DIV_MULTI_SYNC_EN
    assign w_sync = bus.sync_all;
`else
    assign w_sync = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_d;
        logic [CNT_W-1:0] r_p;
        logic             r_pend;
        logic             r_ja;
        logic             r_tick;
        logic             r_run;

        logic             w_hit;
        logic             w_imm;
        logic             w_wrap;
        logic             w_apply;
        logic [CNT_W-1:0] w_deff;
        logic [CNT_W-1:0] w_nc;
        logic [CNT_W:0]   w_h;

        always_comb begin
            w_hit   = bus.div_load && (int'(bus.div_sel) == g);
            // Restart from cnt=0 when the channel was not counting last
            // cycle or a sync is requested; pending value is used right away.
            w_imm   = w_sync || !r_run;
            w_deff  = (r_pend && w_imm) ? r_p : r_d;
            w_wrap  = (r_d >= TWO) && (r_cnt >= r_d - ONE);
            w_apply = r_pend && (w_imm || !bus.en[g] || (r_d < TWO) || w_wrap);
            w_nc    = w_wrap ? '0 : r_cnt + ONE;
            // High time in CNT_W+1 bits so an all-ones divisor cannot overflow.
            w_h     = ({1'b0, r_d} + ONE_W) >> 1;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt  <= '0;
                r_d    <= CNT_W'(DEF_DIV);
                r_p    <= '0;
                r_pend <= 1'b0;
                r_ja   <= 1'b0;
                r_tick <= 1'b0;
                r_run  <= 1'b0;
            end else begin
                if (w_apply) begin
                    r_d <= r_p;
                end
                // A load on the applying edge stays pending for the next boundary.
                if (w_hit) begin
                    r_p    <= bus.div_val;
                    r_pend <= 1'b1;
                end else if (w_apply) begin
                    r_pend <= 1'b0;
                end

                if (!bus.en[g] || (w_deff == '0)) begin
                    r_cnt  <= '0;
                    r_ja   <= 1'b0;
                    r_tick <= 1'b0;
                    r_run  <= 1'b0;
                end else if (w_deff == ONE) begin
                    r_cnt  <= '0;
                    r_ja   <= 1'b1;
                    r_tick <= 1'b1;
                    r_run  <= 1'b0;
                end else if (w_imm) begin
                    r_cnt  <= '0;
                    r_ja   <= 1'b1;
                    r_tick <= 1'b1;
                    r_run  <= 1'b1;
                end else begin
                    r_cnt  <= w_nc;
                    r_ja   <= ({1'b0, w_nc} < w_h);
                    r_tick <= (w_nc == '0);
                    r_run  <= 1'b1;
                end
            end
        end

        assign bus.ja[g]   = r_ja;
        assign bus.tick[g] = r_tick;
        assign bus.pend[g] = r_pend;
    end

endmodule
